// File: rtl/lane_data_memory_pkg.sv
// Shared types and helpers for the lane data memory.
// funct3 codes, FSM state enum, size decode and byte-lane rotation.
package lane_data_memory_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT2 = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic [2:0] size_of(
    input logic [1:0] sz
  );
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] rotl8(
    input logic [31:0] x,
    input logic [1:0]  n
  );
    case (n)
      2'd0:    return x;
      2'd1:    return {x[23:0], x[31:24]};
      2'd2:    return {x[15:0], x[31:16]};
      default: return {x[7:0], x[31:8]};
    endcase
  endfunction

  function automatic logic [31:0] rotr8(
    input logic [31:0] x,
    input logic [1:0]  n
  );
    case (n)
      2'd0:    return x;
      2'd1:    return {x[7:0], x[31:8]};
      2'd2:    return {x[15:0], x[31:16]};
      default: return {x[23:0], x[31:24]};
    endcase
  endfunction

endpackage

// File: rtl/lane_data_memory_bank.sv
// One byte-wide RAM lane: synchronous write enable, synchronous read.
// Ports: clk, we, addr (word index), wdata, rdata (registered).
module mem_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lane_data_memory.sv
// Byte-addressable data memory on four byte-lane banks with a
// valid/ready request port and a one-cycle response pulse.
// Ports: clk, rst_n (sync, active-low), req_valid/req_ready,
// req_write, req_funct3, req_addr, req_wdata, rsp_valid,
// rsp_rdata, rsp_error.
// Optional macro MEM_MISALIGNED_EN: misaligned accesses are served,
// word-crossing ones split into two beats; otherwise they error.
module lane_data_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error
);
  import lane_data_memory_pkg::*;

  localparam int WA = $clog2(DEPTH_WORDS);
  typedef logic [ADDR_WIDTH:0] ext_t;
  localparam ext_t BYTES = ext_t'(4 * DEPTH_WORDS);

  state_t          state;
  state_t          state_nx;
  logic [1:0]      off;
  logic [2:0]      size;
  logic [3:0]      m4;
  logic [3:0]      lo;
  logic [WA-1:0]   word;
  ext_t            end_addr;
  logic            legal;
  logic            range_err;
  logic            mis_err;
  logic            err;
  logic            accept;
  logic [31:0]     wrot;

  logic [3:0]      bank_we;
  logic [WA-1:0]   bank_addr;
  logic [31:0]     bank_wdata;
  logic [31:0]     bank_rdata;

  logic            err_q;
  logic            load_ok_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [31:0]     lanes;
  logic [31:0]     data;
  logic [31:0]     ext;

  assign off  = req_addr[1:0];
  assign size = size_of(req_funct3[1:0]);
  assign word = req_addr[WA+1:2];
  assign wrot = rotl8(req_wdata, off);

  // One extra bit so the end address never wraps to 0.
  assign end_addr  = {1'b0, req_addr}
                   + ext_t'(size) - ext_t'(1);
  assign range_err = end_addr >= BYTES;

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !req_write;
      default:          legal = 1'b0;
    endcase
  end

  always_comb begin
    m4 = 4'b1111;
    case (req_funct3[1:0])
      2'd0:    m4 = 4'b0001;
      2'd1:    m4 = 4'b0011;
      default: m4 = 4'b1111;
    endcase
  end

`ifdef MEM_MISALIGNED_EN
  logic [7:0]    mask8;
  logic [3:0]    hi;
  logic          split_ok;
  logic          split_q;
  logic          write_q;
  logic [3:0]    hi_q;
  logic [31:0]   wrot_q;
  logic [WA-1:0] word_b_q;
  logic [31:0]   hold_q;

  // Bits 7:4 are the lanes spilling into the next word.
  assign mask8    = {4'b0000, m4} << off;
  assign lo       = mask8[3:0];
  assign hi       = mask8[7:4];
  assign mis_err  = 1'b0;
  assign split_ok = (|hi) && !err;
`else
  assign lo      = m4 << off;
  assign mis_err = (size == 3'd2 && off[0])
                || (size == 3'd4 && off != 2'd0);
`endif

  assign err       = !legal || range_err || mis_err;
  assign req_ready = rst_n && (state != BEAT2);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
`ifdef MEM_MISALIGNED_EN
    if (accept)
      state_nx = split_ok ? BEAT2 : RESP;
    else if (state == BEAT2)
      state_nx = RESP;
`else
    if (accept)
      state_nx = RESP;
`endif
  end

  always_comb begin
    bank_we    = 4'b0000;
    bank_addr  = word;
    bank_wdata = wrot;
`ifdef MEM_MISALIGNED_EN
    if (state == BEAT2) begin
      bank_addr  = word_b_q;
      bank_wdata = wrot_q;
      bank_we    = write_q ? hi_q : 4'b0000;
    end else
`endif
    if (accept && req_write && !err)
      bank_we = lo;
    // A reset in BEAT2 abandons the second write.
    if (!rst_n) bank_we = 4'b0000;
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    mem_bank #(
      .DEPTH (DEPTH_WORDS),
      .AW    (WA)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[l]),
      .addr  (bank_addr),
      .wdata (bank_wdata[8*l +: 8]),
      .rdata (bank_rdata[8*l +: 8])
    );
  end

`ifdef MEM_MISALIGNED_EN
  always_ff @(posedge clk) begin
    if (accept) begin
      split_q  <= split_ok;
      write_q  <= req_write;
      hi_q     <= hi;
      wrot_q   <= wrot;
      word_b_q <= word + 1'b1;
    end
    // Word A lanes, read by beat 1, before beat 2 reads A+1.
    if (state == BEAT2) hold_q <= bank_rdata;
  end

  always_comb begin
    lanes = bank_rdata;
    for (int l = 0; l < 4; l++)
      if (split_q && !hi_q[l])
        lanes[8*l +: 8] = hold_q[8*l +: 8];
  end
`else
  assign lanes = bank_rdata;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      load_ok_q <= 1'b0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
    end else if (accept) begin
      err_q     <= err;
      load_ok_q <= !req_write && !err;
      f3_q      <= req_funct3;
      off_q     <= off;
    end
  end

  assign data = rotr8(lanes, off_q);

  always_comb begin
    ext = data;
    case (f3_q)
      F3_B:    ext = {{24{data[7]}}, data[7:0]};
      F3_H:    ext = {{16{data[15]}}, data[15:0]};
      F3_BU:   ext = {24'h0, data[7:0]};
      F3_HU:   ext = {16'h0, data[15:0]};
      default: ext = data;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign rsp_error = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && load_ok_q) ? ext : 32'h0;

endmodule

// File: tb/tb_lane_data_memory.sv
// Self-checking bench for lane_data_memory: directed table,
// hand-written multi-cycle sequences and a random model run.
module tb_lane_data_memory;

  localparam int DW    = 64;
  localparam int BYTES = 4 * DW;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  lane_data_memory #(
    .DEPTH_WORDS (DW),
    .ADDR_WIDTH  (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem_m [BYTES];

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model written from the access rules.
  task automatic model_op(input logic wr,
                          input logic [2:0] f3,
                          input logic [31:0] addr,
                          input logic [31:0] wd,
                          output logic [31:0] rd,
                          output logic er,
                          output int lat);
    int sz;
    longint a;
    logic lg;
    logic mis;
    logic [31:0] v;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    a   = longint'(addr);
    lg  = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MEM_MISALIGNED_EN
    mis = 1'b0;
`else
    mis = (a % sz) != 0;
`endif
    er  = !lg || (a + sz - 1 >= BYTES) || mis;
    rd  = 32'h0;
    lat = 1;
`ifdef MEM_MISALIGNED_EN
    if (!er && (a % 4) + sz > 4) lat = 2;
`endif
    if (!er) begin
      if (wr) begin
        for (int k = 0; k < sz; k++)
          mem_m[int'(a) + k] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < sz; k++)
          v = v | (32'(mem_m[int'(a) + k]) << (8 * k));
        case (f3)
          3'd0:    rd = {{24{v[7]}}, v[7:0]};
          3'd1:    rd = {{16{v[15]}}, v[15:0]};
          3'd4:    rd = {24'h0, v[7:0]};
          3'd5:    rd = {16'h0, v[15:0]};
          default: rd = v;
        endcase
      end
    end
  endtask

  // Drive one request, wait for its response (bounded).
  task automatic issue(input logic wr,
                       input logic [2:0] f3,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       output logic [31:0] rd,
                       output logic er,
                       output int lat,
                       output logic rdy1);
    logic got;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    got  = 1'b0;
    lat  = 0;
    rd   = 32'h0;
    er   = 1'b0;
    rdy1 = 1'b0;
    for (int c = 1; c <= 5 && !got; c++) begin
      @(negedge clk);
      if (c == 1) rdy1 = req_ready;
      if (rsp_valid) begin
        got = 1'b1;
        lat = c;
        rd  = rsp_rdata;
        er  = rsp_error;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: addr %h got no rsp_valid required 1",
               addr);
    end else begin
      @(negedge clk);
      chk("pulse_width", 32'(rsp_valid), 32'h0);
    end
  endtask

  // DUT and model together, compared against the model.
  task automatic run_model(input string nm,
                           input logic wr,
                           input logic [2:0] f3,
                           input logic [31:0] addr,
                           input logic [31:0] wd);
    logic [31:0] rd, erd;
    logic er, eer, r1;
    int lat, elat;
    model_op(wr, f3, addr, wd, erd, eer, elat);
    issue(wr, f3, addr, wd, rd, er, lat, r1);
    chk({nm, " rdata"}, rd, erd);
    chk({nm, " error"}, 32'(er), 32'(eer));
    chk({nm, " latency"}, 32'(lat), 32'(elat));
  endtask

  logic [31:0] rd;
  logic        er;
  logic        r1;
  logic        any_v;
  logic [31:0] a;
  logic [31:0] dm;
  logic        em;
  int          lat;
  int          lm;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_error", 32'(rsp_error), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset req_ready", 32'(req_ready), 32'h1);

    for (int w = 0; w < DW; w++)
      run_model("prefill", 1'b1, 3'd2, 32'(4 * w), $urandom);

    tbl.push_back(vec_t'{1, 2, 32'h10, 32'hDEADBEEF, 0, 0});
    tbl.push_back(vec_t'{0, 2, 32'h10, 0, 32'hDEADBEEF, 0});
    tbl.push_back(vec_t'{1, 0, 32'h11, 32'h00000055, 0, 0});
    tbl.push_back(vec_t'{0, 2, 32'h10, 0, 32'hDEAD55EF, 0});
    tbl.push_back(vec_t'{0, 0, 32'h13, 0, 32'hFFFFFFDE, 0});
    tbl.push_back(vec_t'{0, 4, 32'h13, 0, 32'h000000DE, 0});
    tbl.push_back(vec_t'{0, 5, 32'h12, 0, 32'h0000DEAD, 0});
    tbl.push_back(vec_t'{0, 1, 32'h12, 0, 32'hFFFFDEAD, 0});
    tbl.push_back(vec_t'{0, 1, 32'h10, 0, 32'h000055EF, 0});
    tbl.push_back(vec_t'{1, 2, 32'hFC, 32'hCAFEF00D, 0, 0});
    tbl.push_back(vec_t'{0, 2, 32'hFE, 0, 0, 1});
    tbl.push_back(vec_t'{0, 2, 32'hFC, 0, 32'hCAFEF00D, 0});
    tbl.push_back(vec_t'{0, 3, 32'h10, 0, 0, 1});
    tbl.push_back(vec_t'{1, 4, 32'h10, 32'h0, 0, 1});
    tbl.push_back(vec_t'{0, 2, 32'h10, 0, 32'hDEAD55EF, 0});
    tbl.push_back(vec_t'{1, 2, 32'h14, 32'h0, 0, 0});
    tbl.push_back(vec_t'{1, 1, 32'h14, 32'h1234ABCD, 0, 0});
    tbl.push_back(vec_t'{1, 1, 32'h16, 32'h00009876, 0, 0});
    tbl.push_back(vec_t'{0, 2, 32'h14, 0, 32'h9876ABCD, 0});
    tbl.push_back(vec_t'{0, 0, 32'h14, 0, 32'hFFFFFFCD, 0});
    tbl.push_back(vec_t'{1, 0, 32'hFF, 32'h0000007F, 0, 0});
    tbl.push_back(vec_t'{0, 0, 32'hFF, 0, 32'h0000007F, 0});
    tbl.push_back(vec_t'{1, 1, 32'hFF, 32'h0, 0, 1});
    tbl.push_back(vec_t'{0, 2, 32'hFC, 0, 32'h7FFEF00D, 0});
    tbl.push_back(vec_t'{0, 2, 32'h100, 0, 0, 1});
    tbl.push_back(vec_t'{1, 0, 32'h100, 32'h0, 0, 1});
    tbl.push_back(vec_t'{0, 6, 32'h10, 0, 0, 1});
    tbl.push_back(vec_t'{0, 7, 32'h10, 0, 0, 1});
    tbl.push_back(vec_t'{1, 3, 32'h10, 32'h0, 0, 1});
    tbl.push_back(vec_t'{0, 2, 32'hFFFFFFFC, 0, 0, 1});
    tbl.push_back(vec_t'{1, 0, 32'hFFFFFFFF, 32'h0, 0, 1});
    tbl.push_back(vec_t'{0, 2, 32'h10, 0, 32'hDEAD55EF, 0});

    foreach (tbl[i]) begin
      model_op(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd,
               dm, em, lm);
      issue(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd,
            rd, er, lat, r1);
      chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d error", i), 32'(er),
          32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d latency", i), 32'(lat), 32'h1);
    end

    // Back-to-back loads, one per cycle.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h10;
    @(posedge clk);
    #1;
    req_addr = 32'h14;
    @(negedge clk);
    chk("b2b first valid", 32'(rsp_valid), 32'h1);
    chk("b2b first rdata", rsp_rdata, 32'hDEAD55EF);
    chk("b2b ready in RESP", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b second valid", 32'(rsp_valid), 32'h1);
    chk("b2b second rdata", rsp_rdata, 32'h9876ABCD);
    @(negedge clk);
    chk("b2b idle", 32'(rsp_valid), 32'h0);

    // Misaligned store across the 0x20/0x24 boundary.
    run_model("mis pre0", 1'b1, 3'd2, 32'h20, 32'h11111111);
    run_model("mis pre1", 1'b1, 3'd2, 32'h24, 32'h22222222);
    model_op(1'b1, 3'd2, 32'h21, 32'h11223344, dm, em, lm);
    issue(1'b1, 3'd2, 32'h21, 32'h11223344, rd, er, lat, r1);
`ifdef MEM_MISALIGNED_EN
    chk("mis sw error", 32'(er), 32'h0);
    chk("mis sw latency", 32'(lat), 32'h2);
    chk("mis ready N+1", 32'(r1), 32'h0);
    issue(1'b0, 3'd2, 32'h21, 0, rd, er, lat, r1);
    chk("mis lw21", rd, 32'h11223344);
    chk("mis lw21 latency", 32'(lat), 32'h2);
    issue(1'b0, 3'd2, 32'h20, 0, rd, er, lat, r1);
    chk("mis lw20", rd, 32'h22334411);
    issue(1'b0, 3'd2, 32'h24, 0, rd, er, lat, r1);
    chk("mis lw24", rd, 32'h22222211);
`else
    chk("mis sw error", 32'(er), 32'h1);
    chk("mis sw latency", 32'(lat), 32'h1);
    issue(1'b0, 3'd2, 32'h20, 0, rd, er, lat, r1);
    chk("mis lw20", rd, 32'h11111111);
    issue(1'b0, 3'd2, 32'h24, 0, rd, er, lat, r1);
    chk("mis lw24", rd, 32'h22222222);
    issue(1'b0, 3'd1, 32'h21, 0, rd, er, lat, r1);
    chk("mis lh21 error", 32'(er), 32'h1);
`endif

`ifdef MEM_MISALIGNED_EN
    // Reset lands while the split store sits in BEAT2.
    run_model("rst pre0", 1'b1, 3'd2, 32'h28, 32'h0);
    run_model("rst pre1", 1'b1, 3'd2, 32'h2C, 32'h0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h2B;
    req_wdata  = 32'hAABBCCDD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("beat2 ready", 32'(req_ready), 32'h0);
    rst_n = 1'b0;
    any_v = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_v = any_v | rsp_valid;
    end
    chk("rst beat2 no rsp", 32'(any_v), 32'h0);
    chk("rst beat2 ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst release ready", 32'(req_ready), 32'h1);
    chk("rst release valid", 32'(rsp_valid), 32'h0);
    mem_m[32'h2B] = 8'hDD;
    issue(1'b0, 3'd2, 32'h28, 0, rd, er, lat, r1);
    chk("rst beat1 kept", rd, 32'hDD000000);
    issue(1'b0, 3'd2, 32'h2C, 0, rd, er, lat, r1);
    chk("rst beat2 dropped", rd, 32'h00000000);
`endif

    // Idle reset keeps storage contents.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle rst ready", 32'(req_ready), 32'h0);
    chk("idle rst rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    issue(1'b0, 3'd2, 32'h10, 0, rd, er, lat, r1);
    chk("contents kept", rd, 32'hDEAD55EF);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 7) == 0)
        a = 32'($urandom_range(BYTES - 4, BYTES + 2));
      else
        a = 32'($urandom_range(0, BYTES - 1));
      run_model($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_data_memory.md
# lane_data_memory

Byte-addressable, word-organised data memory for the core's load/store path: a parametrised successor of the single-array byte memory. It adds a valid/ready request port, a registered response, RV32 load/store `funct3` decoding with sign/zero extension, and range and alignment error reporting. It sits between the execute stage's load/store unit and on-chip RAM, built from four byte-lane banks.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; byte capacity is 4×`DEPTH_WORDS`.
- `ADDR_WIDTH`, default 32: request address width.
- `clk` input 1: single clock; everything is rising-edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: block accepts a request this cycle.
- `req_write` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32 encoding. Loads accept 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores accept 0 SB, 1 SH, 2 SW.
- `req_addr` input `ADDR_WIDTH`: byte address.
- `req_wdata` input 32: store data; the low bytes are used for SB and SH.
- `rsp_valid` output 1: one-cycle pulse completing each accepted request, for loads and stores alike.
- `rsp_rdata` output 32: load result after extension; 0 for stores and for errors.
- `rsp_error` output 1: accompanies `rsp_valid`; the access was rejected.

## Operation
- A request is accepted when `req_valid && req_ready`.
- States:
  - IDLE: `req_ready`=1.
  - BEAT2: second half of a split access; `req_ready`=0.
  - RESP: `req_ready`=1 and the response is driven; a new request may be accepted in the same cycle.
- Size is 1, 2 or 4 bytes, taken from `funct3[1:0]`. Little-endian: the byte at `addr+k` maps to data bits `[8k+7:8k]`.
- Error cases, all producing no memory write:
  - Illegal `funct3`: loads 3, 6, 7; stores 3–7.
  - Range: `addr + size - 1 >= 4*DEPTH_WORDS`. Accesses never wrap around to address 0.
  - Misalignment, per Configuration.
- Loads: LB and LH sign-extend from bit 7 and bit 15 respectively. LBU and LHU zero-extend.
- Stores: only the addressed byte lanes are written; all other bytes keep their value.
- Storage contents are not cleared by reset and are X until written.

## Timing
- Single-beat access accepted at cycle N: `rsp_valid` goes high at N+1 for exactly one cycle.
- Store data is visible to a load accepted at N+1 or later.
- Split access accepted at N:
  - N+1: second beat in BEAT2.
  - N+2: response.
- There is no response backpressure; the consumer must sample `rsp_*` when `rsp_valid`=1.
- Back-to-back aligned requests run at one per cycle.
- Reset values: `req_ready`=0 while `rst_n`=0, then 1; `rsp_valid`=0; `rsp_rdata`=0; `rsp_error`=0; state IDLE.
- Reset asserted during BEAT2:
  - The second beat and the response are abandoned.
  - Lanes written by beat 1 stay written.

## Configuration
- `MEM_MISALIGNED_EN` defined:
  - Misaligned accesses that stay within one word (e.g. LH at `addr%4`=1) complete in a single beat.
  - Accesses crossing a word boundary (half at `addr%4`=3; word at `addr%4`≠0) split into two beats: low lanes of word A first, then upper lanes of word A+1.
  - A range violation on either beat yields an error before anything is written.
- `MEM_MISALIGNED_EN` undefined:
  - Any half access at an odd address, or any word access at `addr%4`≠0, gives `rsp_error`=1 at N+1 with no write.
  - The BEAT2 state and its lane-holding register are not synthesised.

## Structure
- Shared package holds:
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - State enum (IDLE/BEAT2/RESP).
  - Size-decode function.
- Sub-module `mem_bank`: one byte-wide RAM with synchronous write enable and synchronous read, instantiated 4× (one per lane), each indexed by word address.
- Top level contains:
  - Lane rotation and byte-enable generation.
  - FSM.
  - Beat-1 read-lane hold register.
  - Extension logic.

## Test plan
- SW `0xDEADBEEF` at `0x10`, then LW `0x10` → `rsp_rdata`=`0xDEADBEEF`, `rsp_error`=0, one cycle after acceptance.
- After the above, SB `0x55` at `0x11`, then LW `0x10` → `0xDEAD55EF`. Then LB `0x13` → `0xFFFFFFDE`; LBU `0x13` → `0x000000DE`; LHU `0x12` → `0x0000DEAD`.
- LW at `4*DEPTH_WORDS-2` → `rsp_error`=1, `rsp_rdata`=0. A following LW of the last word shows it unchanged.
- Misaligned checks, performed as SW `0x11223344` at `0x21`:
  - Macro undefined → error; words `0x20` and `0x24` unchanged.
  - Macro defined → response at N+2; `req_ready`=0 at N+1; LW `0x21` → `0x11223344`.
- Load with `funct3`=3, and store with `funct3`=4 → each gives `rsp_error`=1 with no write.
- Drop `rst_n` during BEAT2 of a split SW → no `rsp_valid`. After release, `req_ready`=1 and the beat-1 bytes read back as written.
